// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin replacement and
// a miss FSM that always completes an accepted fill.
module icache_assoc #(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int ADDR_BITS = 16,
  parameter int XLEN      = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  squash,
  input  logic [XLEN-1:0]       proc2Icache_addr,
  input  logic                  Dcache_on_bus,
  input  logic [3:0]            Imem2proc_response,
  input  logic [63:0]           Imem2proc_data,
  input  logic [3:0]            Imem2proc_tag,
  output logic [1:0]            proc2Imem_command,
  output logic [XLEN-1:0]       proc2Imem_addr,
  output logic [1:0][31:0]      inst_out,
  output logic [1:0]            inst_valid,
  output logic                  miss_busy
);

  localparam int IW = $clog2(SETS);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LW = ADDR_BITS - 3;
  localparam int TW = LW - IW;

  localparam logic [1:0]  BUS_NONE = 2'd0;
  localparam logic [1:0]  BUS_LOAD = 2'd1;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    miss_line_q, miss_line_d;
  logic [3:0]       mem_tag_q, mem_tag_d;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WW-1:0]    rr_q    [SETS];
  logic [TW-1:0]    tag_q   [SETS][WAYS];
  logic [63:0]      data_q  [SETS][WAYS];

  logic [LW-1:0]    pc_line;
  logic [IW-1:0]    pc_idx;
  logic [TW-1:0]    pc_tag;
  logic             pc_off;
  logic [IW-1:0]    fill_idx;
  logic [TW-1:0]    fill_tag;

  assign pc_line  = proc2Icache_addr[ADDR_BITS-1:3];
  assign pc_idx   = pc_line[IW-1:0];
  assign pc_tag   = pc_line[LW-1:IW];
  assign pc_off   = proc2Icache_addr[2];
  assign fill_idx = miss_line_q[IW-1:0];
  assign fill_tag = miss_line_q[LW-1:IW];

  logic [WAYS-1:0]  match;
  logic [63:0]      hit_line;
  logic             hit;

  always_comb begin
    match    = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[pc_idx][w] && tag_q[pc_idx][w] == pc_tag) begin
        match[w] = 1'b1;
        hit_line = hit_line | data_q[pc_idx][w];
      end
    end
  end

  // A duplicate tag in the set is never treated as a hit.
  assign hit = (match != '0) &&
               ((match & (match - WAYS'(1))) == '0);

  always_comb begin
    inst_valid  = {hit & ~pc_off, hit};
    inst_out[0] = NOP;
    inst_out[1] = NOP;
    if (hit) begin
      inst_out[0] = pc_off ? hit_line[63:32]
                           : hit_line[31:0];
      if (!pc_off)
        inst_out[1] = hit_line[63:32];
    end
  end

  logic [WW-1:0]    vic_way;
  logic             vic_free;
  logic [WW-1:0]    rr_next;

  always_comb begin
    vic_free = 1'b0;
    vic_way  = rr_q[fill_idx];
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[fill_idx][w]) begin
        vic_free = 1'b1;
        vic_way  = WW'(w);
      end
    end
    rr_next = (rr_q[fill_idx] == WW'(WAYS-1)) ? '0
            : rr_q[fill_idx] + WW'(1);
  end

  logic line_ok;
  logic req_go;
  logic fill_en;

  assign line_ok = (pc_line == miss_line_q);
  assign req_go  = (state_q == S_REQ) && !squash &&
                   line_ok && !Dcache_on_bus;
  assign fill_en = (state_q == S_WAIT) &&
                   (Imem2proc_tag == mem_tag_q);

  always_comb begin
    state_d     = state_q;
    miss_line_d = miss_line_q;
    mem_tag_d   = mem_tag_q;
    unique case (state_q)
      S_IDLE: begin
        if (!hit) begin
          state_d     = S_REQ;
          miss_line_d = pc_line;
        end
      end
      S_REQ: begin
        if (squash || !line_ok) begin
          state_d = S_IDLE;
        end else if (req_go && Imem2proc_response != 4'd0) begin
          state_d   = S_WAIT;
          mem_tag_d = Imem2proc_response;
        end
      end
      S_WAIT: begin
        if (fill_en)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      miss_line_q <= '0;
      mem_tag_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      mem_tag_q   <= mem_tag_d;
      if (fill_en) begin
        valid_q[fill_idx][vic_way] <= 1'b1;
        if (!vic_free)
          rr_q[fill_idx] <= rr_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[fill_idx][vic_way]  <= fill_tag;
      data_q[fill_idx][vic_way] <= Imem2proc_data;
    end
  end

  assign proc2Imem_command = req_go ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = {proc2Icache_addr[XLEN-1:ADDR_BITS],
                              (state_q == S_REQ) ? miss_line_q : pc_line,
                              3'b000};
  assign miss_busy         = (state_q != S_IDLE);

endmodule
